kd_node_param: RTL

//  Parametrised kd-tree node for the hardware k-means tree. Holds one DIMS-dimensional

---
 rtl/kd_node_param.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/kd_node_param.sv
// kd-tree node: holds one DIMS-dimensional center, serves its parent and relays to two children.
// All outputs registered; every link uses a 4-phase command/response handshake.
module kd_node_param #(
   parameter int DIMS      = 3,
   parameter int COORD_W   = 8,
   parameter bit HAS_LEFT  = 1'b1,
   parameter bit HAS_RIGHT = 1'b1,
   parameter int CMD_W     = 5,
   localparam int DATA_W   = DIMS * COORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CMD_W-1:0]  cmd_from_top,
   input  logic [DATA_W-1:0] data_from_top,
   input  logic [CMD_W-1:0]  cmd_from_left,
   input  logic [DATA_W-1:0] data_from_left,
   input  logic [CMD_W-1:0]  cmd_from_right,
   input  logic [DATA_W-1:0] data_from_right,
   output logic [CMD_W-1:0]  cmd_to_top,
   output logic [DATA_W-1:0] data_to_top,
   output logic [CMD_W-1:0]  cmd_to_left,
   output logic [DATA_W-1:0] data_to_left,
   output logic [CMD_W-1:0]  cmd_to_right,
   output logic [DATA_W-1:0] data_to_right
);

   localparam int AW = $clog2(DIMS);

   localparam logic [CMD_W-1:0] NOP       = CMD_W'(5'b00000);
   localparam logic [CMD_W-1:0] RST       = CMD_W'(5'b11111);
   localparam logic [CMD_W-1:0] RST_DONE  = CMD_W'(5'b11110);
   localparam logic [CMD_W-1:0] FILL      = CMD_W'(5'b00001);
   localparam logic [CMD_W-1:0] FILL_ACK  = CMD_W'(5'b00110);
   localparam logic [CMD_W-1:0] FILL_DONE = CMD_W'(5'b00101);
   localparam logic [CMD_W-1:0] CFG       = CMD_W'(5'b00010);
   localparam logic [CMD_W-1:0] CFG_DONE  = CMD_W'(5'b00111);
   localparam logic [CMD_W-1:0] SORT      = CMD_W'(5'b01001);
   localparam logic [CMD_W-1:0] SORT_DONE = CMD_W'(5'b01010);
   localparam logic [CMD_W-1:0] XCHG      = CMD_W'(5'b00011);
   localparam logic [CMD_W-1:0] XCHG_ACK  = CMD_W'(5'b00100);
   localparam logic [CMD_W-1:0] DNE       = CMD_W'(5'b10000);

   typedef enum logic [2:0] {IDLE, RST_WAIT, FILL_L, FILL_R, CFG_WAIT, SORT_L, SORT_R, RESP} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] center_q;
   logic [AW-1:0]     axis_q;
   logic              filled_q, left_full_q, right_full_q, swapped_q, xpend_q;
   logic              wait_l_q, wait_r_q;
   logic [CMD_W-1:0]  cmd_to_top_q, cmd_to_left_q, cmd_to_right_q;
   logic [DATA_W-1:0] data_to_top_q, data_to_left_q, data_to_right_q;

   function automatic logic [COORD_W-1:0] coord(input logic [DATA_W-1:0] d, input logic [AW-1:0] a);
      logic [COORD_W-1:0] r;
      r = '0;
      for (int i = 0; i < DIMS; i++)
         if (a == AW'(i)) r = d[i*COORD_W +: COORD_W];
      return r;
   endfunction

   // Absent children behave exactly like a stub that answers DNE forever.
   logic [CMD_W-1:0]  l_cmd, r_cmd;
   logic [DATA_W-1:0] l_dat, r_dat;
   assign l_cmd = HAS_LEFT  ? cmd_from_left   : DNE;
   assign r_cmd = HAS_RIGHT ? cmd_from_right  : DNE;
   assign l_dat = HAS_LEFT  ? data_from_left  : '0;
   assign r_dat = HAS_RIGHT ? data_from_right : '0;

   logic [AW-1:0]      cfg_raw, cfg_axis, child_axis;
   logic [CMD_W-1:0]   exp_rsp;
   logic               l_fin, r_fin, rst_req;
   logic [COORD_W-1:0] c_self, c_left, c_right;

   assign cfg_raw    = data_from_top[AW-1:0];
   assign cfg_axis   = ({1'b0, cfg_raw} >= (AW+1)'(DIMS)) ? cfg_raw - AW'(DIMS) : cfg_raw;
   assign child_axis = (cfg_axis == AW'(DIMS-1)) ? '0 : cfg_axis + AW'(1);
   assign exp_rsp    = (state_q == RST_WAIT) ? RST_DONE : CFG_DONE;
   assign l_fin      = !wait_l_q || l_cmd == exp_rsp || l_cmd == DNE;
   assign r_fin      = !wait_r_q || r_cmd == exp_rsp || r_cmd == DNE;
   assign c_self     = coord(center_q, axis_q);
   assign c_left     = coord(l_dat, axis_q);
   assign c_right    = coord(r_dat, axis_q);
   // A held RST (waiting or already answered) must not restart the reset sequence.
   assign rst_req    = cmd_from_top == RST && state_q != RST_WAIT &&
                       !(state_q == RESP && cmd_to_top_q == RST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         center_q        <= '0;
         axis_q          <= '0;
         filled_q        <= 1'b0;
         left_full_q     <= 1'b0;
         right_full_q    <= 1'b0;
         swapped_q       <= 1'b0;
         xpend_q         <= 1'b0;
         wait_l_q        <= 1'b0;
         wait_r_q        <= 1'b0;
         cmd_to_top_q    <= NOP;
         data_to_top_q   <= '0;
         cmd_to_left_q   <= NOP;
         data_to_left_q  <= '0;
         cmd_to_right_q  <= NOP;
         data_to_right_q <= '0;
      end else if (rst_req) begin
         state_q         <= RST_WAIT;
         center_q        <= '0;
         axis_q          <= '0;
         filled_q        <= 1'b0;
         left_full_q     <= 1'b0;
         right_full_q    <= 1'b0;
         swapped_q       <= 1'b0;
         xpend_q         <= 1'b0;
         wait_l_q        <= 1'b1;
         wait_r_q        <= 1'b1;
         cmd_to_top_q    <= NOP;
         data_to_top_q   <= '0;
         cmd_to_left_q   <= RST;
         data_to_left_q  <= '0;
         cmd_to_right_q  <= RST;
         data_to_right_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               data_to_top_q <= center_q;
               case (cmd_from_top)
                  FILL: begin
                     if (!filled_q) begin
                        center_q      <= data_from_top;
                        filled_q      <= 1'b1;
                        cmd_to_top_q  <= FILL_ACK;
                        data_to_top_q <= '0;
                        state_q       <= RESP;
                     end else if (!left_full_q) begin
                        cmd_to_left_q  <= FILL;
                        data_to_left_q <= data_from_top;
                        state_q        <= FILL_L;
                     end else if (!right_full_q) begin
                        cmd_to_right_q  <= FILL;
                        data_to_right_q <= data_from_top;
                        state_q         <= FILL_R;
                     end else begin
                        cmd_to_top_q  <= FILL_DONE;
                        data_to_top_q <= '0;
                        state_q       <= RESP;
                     end
                  end
                  CFG: begin
                     axis_q          <= cfg_axis;
                     cmd_to_left_q   <= CFG;
                     data_to_left_q  <= DATA_W'(child_axis);
                     cmd_to_right_q  <= CFG;
                     data_to_right_q <= DATA_W'(child_axis);
                     wait_l_q        <= 1'b1;
                     wait_r_q        <= 1'b1;
                     state_q         <= CFG_WAIT;
                  end
                  SORT: begin
                     swapped_q <= 1'b0;
                     xpend_q   <= 1'b0;
                     state_q   <= SORT_L;
                  end
                  XCHG: begin
                     center_q      <= data_from_top;
                     cmd_to_top_q  <= XCHG_ACK;
                     data_to_top_q <= center_q;
                     state_q       <= RESP;
                  end
                  default: ;
               endcase
            end
            RST_WAIT, CFG_WAIT: begin
               if (wait_l_q && l_fin) begin
                  wait_l_q       <= 1'b0;
                  cmd_to_left_q  <= NOP;
                  data_to_left_q <= '0;
               end
               if (wait_r_q && r_fin) begin
                  wait_r_q        <= 1'b0;
                  cmd_to_right_q  <= NOP;
                  data_to_right_q <= '0;
               end
               if (l_fin && r_fin) begin
                  cmd_to_top_q  <= exp_rsp;
                  data_to_top_q <= '0;
                  state_q       <= RESP;
               end
            end
            FILL_L: begin
               if (l_cmd == FILL_ACK) begin
                  cmd_to_left_q  <= NOP;
                  data_to_left_q <= '0;
                  cmd_to_top_q   <= FILL_ACK;
                  data_to_top_q  <= '0;
                  state_q        <= RESP;
               end else if (l_cmd == FILL_DONE || l_cmd == DNE) begin
                  left_full_q    <= 1'b1;
                  cmd_to_left_q  <= NOP;
                  data_to_left_q <= '0;
                  if (right_full_q) begin
                     cmd_to_top_q  <= FILL_DONE;
                     data_to_top_q <= '0;
                     state_q       <= RESP;
                  end else begin
                     cmd_to_right_q  <= FILL;
                     data_to_right_q <= data_from_top;
                     state_q         <= FILL_R;
                  end
               end
            end
            FILL_R: begin
               if (r_cmd == FILL_ACK || r_cmd == FILL_DONE || r_cmd == DNE) begin
                  if (r_cmd != FILL_ACK) right_full_q <= 1'b1;
                  cmd_to_right_q  <= NOP;
                  data_to_right_q <= '0;
                  cmd_to_top_q    <= (r_cmd == FILL_ACK) ? FILL_ACK : FILL_DONE;
                  data_to_top_q   <= '0;
                  state_q         <= RESP;
               end
            end
            SORT_L: begin
               if (xpend_q) begin
                  if (l_cmd == XCHG_ACK) begin
                     center_q       <= l_dat;
                     swapped_q      <= 1'b1;
                     xpend_q        <= 1'b0;
                     cmd_to_left_q  <= NOP;
                     data_to_left_q <= '0;
                     state_q        <= SORT_R;
                  end
               end else if (l_cmd != DNE && c_left > c_self) begin
                  cmd_to_left_q  <= XCHG;
                  data_to_left_q <= center_q;
                  xpend_q        <= 1'b1;
               end else begin
                  state_q <= SORT_R;
               end
            end
            SORT_R: begin
               if (xpend_q) begin
                  if (r_cmd == XCHG_ACK) begin
                     center_q        <= r_dat;
                     swapped_q       <= 1'b1;
                     xpend_q         <= 1'b0;
                     cmd_to_right_q  <= NOP;
                     data_to_right_q <= '0;
                     cmd_to_top_q    <= SORT_DONE;
                     data_to_top_q   <= DATA_W'(1'b1);
                     state_q         <= RESP;
                  end
               end else if (r_cmd != DNE && c_right < c_self) begin
                  cmd_to_right_q  <= XCHG;
                  data_to_right_q <= center_q;
                  xpend_q         <= 1'b1;
               end else begin
                  cmd_to_top_q  <= SORT_DONE;
                  data_to_top_q <= DATA_W'(swapped_q);
                  state_q       <= RESP;
               end
            end
            RESP: begin
               if (cmd_from_top == NOP) begin
                  cmd_to_top_q  <= NOP;
                  data_to_top_q <= center_q;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_to_top    = cmd_to_top_q;
   assign data_to_top   = data_to_top_q;
   assign cmd_to_left   = HAS_LEFT  ? cmd_to_left_q   : NOP;
   assign data_to_left  = HAS_LEFT  ? data_to_left_q  : '0;
   assign cmd_to_right  = HAS_RIGHT ? cmd_to_right_q  : NOP;
   assign data_to_right = HAS_RIGHT ? data_to_right_q : '0;

endmodule
